dff_write_arbiter: RTL and testbench
====================================

Name: dff_write_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop storage register between NREQ requesters.
- Uses round-robin arbitration, a registered one-hot grant and a bounded write burst per grant.
- Drives the stored value as q and its complement q_bar.
- Sits in front of the shared D-flip-flop datapath as its write controller.

Parameters:
- NREQ, 4: number of requesters, at least 2.
- WIDTH, 8: stored data width.
- MAX_BURST, 4: maximum writes per grant tenure, at least 1.
- RST_VAL, 0: value loaded into q on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  request per requester; bit i belongs to requester i.
- d_in  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH].
- gnt  out  NREQ  registered one-hot grant, all-zero when idle.
- owner  out  max(1,clog2(NREQ))  index of current grant holder, last holder when idle.
- q  out  WIDTH  stored value.
- q_bar  out  WIDTH  bitwise complement of q, always equal to ~q.
- valid  out  1  high once q has been written at least once since reset.

Behaviour:
- Reset (rst=0 at an edge, takes priority over everything):
  - gnt=0, owner=0, round-robin pointer ptr=0, burst count cnt=0, state IDLE.
  - q=RST_VAL, q_bar=~RST_VAL, valid=0.
  - No write happens at that edge, even mid-burst.
- State IDLE (gnt=0):
  - At an edge with any req bit high: winner = first set req bit searching ptr, ptr+1, ... mod NREQ.
  - gnt <= onehot(winner), owner <= winner, cnt <= 0, state GRANT.
  - No write happens at this edge.
- State GRANT (gnt[owner]=1):
  - Write: at an edge with req[owner]=1, q <= d_in[owner], q_bar <= ~d_in[owner], valid <= 1, cnt <= cnt+1.
  - Release condition: req[owner]=0 at the edge (no write that edge), or this edge performs write number MAX_BURST (cnt==MAX_BURST-1).
  - On release: ptr <= owner+1 mod NREQ.
    - Re-arbitrate at the same edge from the new ptr over all req bits except the owner's.
    - If a winner exists: gnt <= onehot(winner), owner <= winner, cnt <= 0, stay GRANT. There is no bubble cycle.
    - Otherwise, if req[owner] is still high (burst-limit case only): re-grant the same owner, cnt <= 0.
    - Otherwise: gnt <= 0, state IDLE; owner keeps its last value.
- Latency:
  - req rising before edge k gives gnt visible after edge k.
  - The first write occurs at edge k+1; the new q is visible after edge k+1.
- Non-owners' req and d_in are ignored while another requester holds the grant.
- Never more than one gnt bit high; never more than one write per cycle.
- ptr wraps from NREQ-1 to 0.
- MAX_BURST=1 gives strict round-robin with one write per grant.

Test Plan (NREQ=4, WIDTH=8, MAX_BURST=4, RST_VAL=0):
1. Reset: rst=0 for 2 edges with req=4'b1111, d_in all 8'hAA.
   - Required: gnt=0, q=8'h00, q_bar=8'hFF, valid=0 throughout; no write.
2. Single write: after reset, req=4'b0001, d_in[0]=8'hA5.
   - Required: gnt=4'b0001 after edge 1; q=8'hA5, q_bar=8'h5A, valid=1 after edge 2.
   - After req drops: gnt=0 one edge later; q holds 8'hA5.
3. Burst limit: req0 held 6 cycles with d_in[0]=01,02,...,06; req1 high with d_in[1]=8'hF0.
   - Required: q sequence 01,02,03,04; then gnt=4'b0010 at the same edge as the 4th write.
   - Next edge: q=F0; 05 and 06 are never written.
4. Round-robin fairness: req=4'b1111 held 20 cycles, d_in[i]=8'h10*i.
   - Required grant order: 0,1,2,3,0.
   - Each grant yields exactly 4 writes; no idle cycle between grants.
5. Early release: requester 2 holds the grant, drops req2 after 2 writes; req3 pending.
   - Required: gnt=4'b1000 at the drop edge; no write at that edge.
   - Next edge: q=d_in[3].
6. Reset mid-burst: during GRANT with d_in[owner]=8'h77, assert rst=0 for 1 edge.
   - Required: q=8'h00, q_bar=8'hFF, valid=0, gnt=0; 8'h77 never appears on q.
   - After release, req=4'b0100 gives a grant to requester 2, with ptr restarting from 0.

Source files
------------

// File: rtl/dff_write_arbiter_if.sv
// Bus between the requesters and the shared-register write arbiter: requests and
// write data in, one-hot grant, owner index and stored value back out.
interface dff_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int OW    = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d_in;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_bar;
    logic                  valid;

    // Requester side drives requests and data, observes grant and storage.
    modport master (
        output req, d_in,
        input  gnt, owner, q, q_bar, valid
    );

    // Arbiter side.
    modport slave (
        input  req, d_in,
        output gnt, owner, q, q_bar, valid
    );
endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write controller for one shared WIDTH-bit register: registered one-hot
// grant, bounded burst per tenure, same-edge hand-over to the next requester.
module dff_write_arbiter #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 8,
    parameter int               MAX_BURST = 4,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                clk,
    input  logic                rst,
    dff_write_arbiter_if.slave  bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state;
    logic [OW-1:0]    ptr;
    logic [OW-1:0]    owner;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] q;
    logic             valid;

    // {found, index}: first set bit of vec scanning start, start+1, ... modulo NREQ.
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] vec,
                                            input logic [OW-1:0]   start);
        logic [OW:0] res;
        int          idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NREQ;
            if (vec[idx]) res = {1'b1, OW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [OW:0]      idle_pick;
    logic [OW:0]      handover_pick;
    logic [OW-1:0]    next_ptr;
    logic             owner_req;
    logic             write_en;
    logic             last_write;
    logic             release_now;
    logic [WIDTH-1:0] owner_data;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        idle_pick     = rr_pick(bus.req, ptr);
        next_ptr      = OW'((int'(owner) + 1) % NREQ);
        handover_pick = rr_pick(bus.req & ~onehot(owner), next_ptr);
        owner_req     = bus.req[owner];
        owner_data    = bus.d_in[owner*WIDTH +: WIDTH];
        write_en      = (state == ST_GRANT) && owner_req;
        last_write    = (cnt == CW'(MAX_BURST - 1));
        release_now   = (state == ST_GRANT) && (!owner_req || last_write);
    end

    // NOTE: sequential state uses non-blocking assignments only; the later release
    // assignment to cnt deliberately overrides the increment from the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            gnt   <= '0;
            q     <= RST_VAL;
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_pick[OW]) begin
                        gnt   <= onehot(idle_pick[OW-1:0]);
                        owner <= idle_pick[OW-1:0];
                        cnt   <= '0;
                        state <= ST_GRANT;
                    end
                end
                default: begin
                    if (write_en) begin
                        q     <= owner_data;
                        valid <= 1'b1;
                        cnt   <= cnt + CW'(1);
                    end
                    if (release_now) begin
                        ptr <= next_ptr;
                        if (handover_pick[OW]) begin
                            gnt   <= onehot(handover_pick[OW-1:0]);
                            owner <= handover_pick[OW-1:0];
                            cnt   <= '0;
                        end else if (owner_req) begin
                            // Burst limit hit with nobody else waiting: fresh tenure.
                            cnt <= '0;
                        end else begin
                            gnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.owner = owner;
    assign bus.q     = q;
    assign bus.q_bar = ~q;
    assign bus.valid = valid;

    gnt_onehot_a: assert property (@(posedge clk) $onehot0(gnt));
    gnt_state_a:  assert property (@(posedge clk) (state == ST_GRANT) == (gnt != '0));
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4, RST_VAL=0);
// every expected value is hand-derived from the intended behaviour.
module tb_dff_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dff_write_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    dff_write_arbiter #(
        .NREQ(4), .WIDTH(8), .MAX_BURST(4), .RST_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        bus.d_in = {d3, d2, d1, d0};
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_gnt;

        // 1. Reset held with every requester active: no grant, no write.
        rst     = 1'b0;
        bus.req = 4'b1111;
        set_data(8'hAA, 8'hAA, 8'hAA, 8'hAA);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_gnt", bus.gnt, 4'b0000);
            check("rst_q", bus.q, 8'h00);
            check("rst_qbar", bus.q_bar, 8'hFF);
            check("rst_valid", bus.valid, 1'b0);
        end
        rst     = 1'b1;
        bus.req = 4'b0000;
        tick();
        check("idle_gnt", bus.gnt, 4'b0000);

        // 2. Single write from requester 0.
        bus.req = 4'b0001;
        set_data(8'hA5, 8'h00, 8'h00, 8'h00);
        tick();
        check("sw_gnt", bus.gnt, 4'b0001);
        check("sw_q_before", bus.q, 8'h00);
        check("sw_valid_before", bus.valid, 1'b0);
        tick();
        check("sw_q", bus.q, 8'hA5);
        check("sw_qbar", bus.q_bar, 8'h5A);
        check("sw_valid", bus.valid, 1'b1);
        bus.req = 4'b0000;
        tick();
        check("sw_release_gnt", bus.gnt, 4'b0000);
        check("sw_hold_q", bus.q, 8'hA5);
        check("sw_owner_kept", bus.owner, 0);

        // 3. Burst limit: requester 0 gets four writes, then requester 1 takes over.
        bus.req = 4'b0001;
        set_data(8'h01, 8'hF0, 8'h00, 8'h00);
        tick();
        check("bl_gnt0", bus.gnt, 4'b0001);
        bus.req = 4'b0011;
        for (int i = 1; i <= 4; i++) begin
            set_data(8'(i), 8'hF0, 8'h00, 8'h00);
            tick();
            check("bl_q", bus.q, 32'(i));
            check("bl_gnt", bus.gnt, (i == 4) ? 4'b0010 : 4'b0001);
        end
        set_data(8'h05, 8'hF0, 8'h00, 8'h00);
        tick();
        check("bl_handover_q", bus.q, 8'hF0);
        set_data(8'h06, 8'hF0, 8'h00, 8'h00);
        tick();
        check("bl_no_06", bus.q, 8'hF0);
        check("bl_owner1", bus.owner, 1);
        bus.req = 4'b0000;
        tick();
        check("bl_idle", bus.gnt, 4'b0000);

        // 4. Round-robin fairness from a freshly reset pointer.
        rst = 1'b0;
        tick();
        rst     = 1'b1;
        bus.req = 4'b1111;
        set_data(8'h00, 8'h10, 8'h20, 8'h30);
        tick();
        check("rr_first_gnt", bus.gnt, 4'b0001);
        for (int g = 0; g < 5; g++) begin
            for (int w = 0; w < 4; w++) begin
                tick();
                check("rr_q", bus.q, 32'(8'h10 * order[g]));
                exp_gnt = (w < 3) ? 4'(1 << order[g]) : 4'(1 << ((order[g] + 1) % 4));
                check("rr_gnt", bus.gnt, exp_gnt);
            end
        end
        bus.req = 4'b0000;
        tick();
        check("rr_idle", bus.gnt, 4'b0000);

        // 5. Early release by requester 2 with requester 3 pending.
        bus.req = 4'b0100;
        set_data(8'h00, 8'h00, 8'hC2, 8'hD3);
        tick();
        check("er_gnt2", bus.gnt, 4'b0100);
        bus.req = 4'b1100;
        tick();
        check("er_w1", bus.q, 8'hC2);
        set_data(8'h00, 8'h00, 8'hC3, 8'hD3);
        tick();
        check("er_w2", bus.q, 8'hC3);
        bus.req = 4'b1000;
        tick();
        check("er_gnt3", bus.gnt, 4'b1000);
        check("er_no_write", bus.q, 8'hC3);
        tick();
        check("er_q3", bus.q, 8'hD3);
        bus.req = 4'b0000;
        tick();
        check("er_idle", bus.gnt, 4'b0000);

        // 6. Reset mid-burst after moving the pointer away from zero.
        bus.req = 4'b0010;
        set_data(8'h00, 8'h11, 8'h00, 8'h77);
        tick();
        tick();
        check("mb_pre_q", bus.q, 8'h11);
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1000;
        tick();
        check("mb_gnt3", bus.gnt, 4'b1000);
        rst = 1'b0;
        tick();
        check("mb_q", bus.q, 8'h00);
        check("mb_qbar", bus.q_bar, 8'hFF);
        check("mb_valid", bus.valid, 1'b0);
        check("mb_gnt", bus.gnt, 4'b0000);
        check("mb_owner", bus.owner, 0);
        rst     = 1'b1;
        bus.req = 4'b1010;
        tick();
        check("mb_ptr_reset", bus.gnt, 4'b0010);
        check("mb_no_77", bus.q, 8'h00);
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0100;
        tick();
        check("mb_gnt2", bus.gnt, 4'b0100);
        check("mb_owner2", bus.owner, 2);
        bus.req = 4'b0000;
        tick();
        check("end_idle", bus.gnt, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
